ex_muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the EX stage. Executes RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over a fixed number of cycles.
- Holds the pipeline with a stall while it works, using a level req / pulse done handshake.
- Sits beside the ALU. The EX-stage result mux selects md_result when the instruction is an M-extension op.

---
 rtl/ex_muldiv_seq_pkg.sv | 39 +++
 rtl/ex_muldiv_seq_if.sv | 31 +++
 rtl/ex_muldiv_seq_md_core.sv | 68 ++++++
 rtl/ex_muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// ex_muldiv_seq_pkg: shared types for the iterative RV32M multiply/divide sequencer.
//   md_op_e    - M-extension op select codes (funct3 order)
//   md_state_e - sequencer FSM states
//   helpers    - op classification used by the sign handling
package ex_muldiv_seq_pkg;

    typedef enum logic [2:0] {
        MdMul    = 3'b000,
        MdMulh   = 3'b001,
        MdMulhsu = 3'b010,
        MdMulhu  = 3'b011,
        MdDiv    = 3'b100,
        MdDivu   = 3'b101,
        MdRem    = 3'b110,
        MdRemu   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        MdSIdle = 3'd0,
        MdSPrep = 3'd1,
        MdSCalc = 3'd2,
        MdSFix  = 3'd3,
        MdSDone = 3'd4
    } md_state_e;

    // Divide/remainder ops all have bit 2 set.
    function automatic logic is_div_op(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input md_op_e op);
        return (op == MdMulh) || (op == MdMulhsu) || (op == MdDiv) || (op == MdRem);
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return (op == MdMulh) || (op == MdDiv) || (op == MdRem);
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if: EX-stage <-> multiply/divide sequencer handshake bundle.
//   md_req    - level request from EX, low aborts
//   md_op     - op select (md_op_e encoding)
//   md_a/md_b - rs1/rs2 operands
//   md_done   - one-cycle completion pulse
//   md_result - registered result, valid while md_done is high
//   md_busy   - sequencer not idle
//   md_stall  - pipeline freeze request
// master = EX stage, slave = sequencer.
interface ex_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            md_req;
    logic [2:0]      md_op;
    logic [XLEN-1:0] md_a;
    logic [XLEN-1:0] md_b;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic            md_busy;
    logic            md_stall;

    modport master (
        output md_req, md_op, md_a, md_b,
        input  md_done, md_result, md_busy, md_stall
    );

    modport slave (
        input  md_req, md_op, md_a, md_b,
        output md_done, md_result, md_busy, md_stall
    );
endinterface

// File: rtl/ex_muldiv_seq_md_core.sv
// ex_muldiv_seq_md_core: 2*XLEN accumulator and one iteration step of an unsigned
// shift-add multiply or a restoring shift-subtract divide.
//   clk, rst - clock, asynchronous active-high reset
//   clear    - zero the accumulator
//   step     - perform one iteration
//   is_div   - select divide step (else multiply step)
//   a, b     - operand magnitudes (multiplicand/multiplier, dividend/divisor)
//   count    - iteration index 0..XLEN-1
//   acc      - multiply: full product; divide: {remainder, quotient}
module ex_muldiv_seq_md_core #(
    parameter int unsigned XLEN = 32,
    localparam int unsigned CntW = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [CntW-1:0]   count,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   rem_new;
    logic              q_bit;
    logic [CntW-1:0]   div_idx;

    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier bit is set,
        // then shift the whole accumulator (plus carry) right by one.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b[count] ? {1'b0, a} : '0);

        // Divide: dividend bits enter MSB first; the quotient builds in the low half.
        div_idx = CntW'(XLEN - 1) - count;
        rem_sh  = {acc_q[2*XLEN-1:XLEN], a[div_idx]};
        diff    = rem_sh - {1'b0, b};
        q_bit   = ~diff[XLEN];
        rem_new = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];

        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (step) begin
            if (is_div) begin
                acc_d = {rem_new, acc_q[XLEN-2:0], q_bit};
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// Fixed latency: request sampled at edge E0, md_done high in the cycle after E0+34.
//   cpu_clk - clock
//   cpu_rst - asynchronous active-high reset
//   md      - slave side of the EX handshake bundle (req/op/a/b in; done/result/busy/stall out)
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    ex_muldiv_seq_if.slave        md
);

    localparam int unsigned CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

    md_state_e       state_q;
    md_op_e          op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [CntW-1:0] count_q;
    logic            sa_q;
    logic            sb_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   orig_a;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   fix_result;
    logic              sa_next;
    logic              sb_next;
    logic              b_zero;
    logic              core_clear;
    logic              core_step;

    assign core_clear = (state_q == MdSPrep) && md.md_req;
    assign core_step  = (state_q == MdSCalc) && md.md_req;

    ex_muldiv_seq_md_core #(
        .XLEN (XLEN)
    ) u_md_core (
        .clk    (cpu_clk),
        .rst    (cpu_rst),
        .clear  (core_clear),
        .step   (core_step),
        .is_div (is_div_op(op_q)),
        .a      (a_q),
        .b      (b_q),
        .count  (count_q),
        .acc    (acc)
    );

    always_comb begin
        // Sign extraction used in PREP (a_q/b_q still hold the raw operands then).
        sa_next = op_signed_a(op_q) & a_q[XLEN-1];
        sb_next = op_signed_b(op_q) & b_q[XLEN-1];
        mag_a   = sa_next ? -a_q : a_q;
        mag_b   = sb_next ? -b_q : b_q;

        // FIX: a_q/b_q now hold magnitudes; re-apply sign to recover the original rs1.
        quo      = acc[XLEN-1:0];
        rem      = acc[2*XLEN-1:XLEN];
        prod_fix = (sa_q ^ sb_q) ? -acc : acc;
        orig_a   = sa_q ? -a_q : a_q;
        b_zero   = (b_q == '0);

        fix_result = '0;
        case (op_q)
            MdMul:                      fix_result = prod_fix[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu:  fix_result = prod_fix[2*XLEN-1:XLEN];
            MdDiv, MdDivu:              fix_result = b_zero ? '1 :
                                                     ((sa_q ^ sb_q) ? -quo : quo);
            MdRem, MdRemu:              fix_result = b_zero ? orig_a :
                                                     (sa_q ? -rem : rem);
            default:                    fix_result = '0;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q  <= MdSIdle;
            op_q     <= MdMul;
            a_q      <= '0;
            b_q      <= '0;
            count_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MdSIdle: begin
                    if (md.md_req) begin
                        op_q    <= md_op_e'(md.md_op);
                        a_q     <= md.md_a;
                        b_q     <= md.md_b;
                        state_q <= MdSPrep;
                    end
                end
                MdSPrep: begin
                    if (!md.md_req) begin
                        state_q <= MdSIdle;
                    end else begin
                        sa_q    <= sa_next;
                        sb_q    <= sb_next;
                        a_q     <= mag_a;
                        b_q     <= mag_b;
                        count_q <= '0;
                        state_q <= MdSCalc;
                    end
                end
                MdSCalc: begin
                    // Abort wins over the CALC->FIX transition.
                    if (!md.md_req) begin
                        state_q <= MdSIdle;
                    end else begin
                        count_q <= count_q + CntW'(1);
                        if (count_q == LastCnt) begin
                            state_q <= MdSFix;
                        end
                    end
                end
                MdSFix: begin
                    if (!md.md_req) begin
                        state_q <= MdSIdle;
                    end else begin
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                        state_q  <= MdSDone;
                    end
                end
                MdSDone: begin
                    state_q <= MdSIdle;
                end
                default: begin
                    state_q <= MdSIdle;
                end
            endcase
        end
    end

    assign md.md_done   = done_q;
    assign md.md_result = result_q;
    assign md.md_busy   = (state_q != MdSIdle);
    assign md.md_stall  = md.md_req & ~done_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed-vector bench for ex_muldiv_seq.
module tb_ex_muldiv_seq;
    import ex_muldiv_seq_pkg::*;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    int   n_vec   = 0;
    int   n_bad   = 0;

    always #5 cpu_clk = ~cpu_clk;

    ex_muldiv_seq_if #(.XLEN(32)) md_bus ();

    ex_muldiv_seq #(
        .XLEN (32)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .md      (md_bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; samples #1 later each cycle until md_done.
    task automatic wait_done(output int cyc, output int stalls);
        cyc    = 0;
        stalls = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (md_bus.md_done) return;
            if (md_bus.md_stall) stalls++;
            @(negedge cpu_clk);
            cyc++;
        end
        check_eq("done timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        int stalls;
        @(negedge cpu_clk);
        md_bus.md_req = 1'b1;
        md_bus.md_op  = op;
        md_bus.md_a   = a;
        md_bus.md_b   = b;
        wait_done(cyc, stalls);
        check_eq({tag, " result"}, md_bus.md_result, exp);
        check_eq({tag, " latency"}, 32'(cyc), 32'd35);
        check_eq({tag, " stall cycles"}, 32'(stalls), 32'd35);
        check_eq({tag, " stall at done"}, {31'd0, md_bus.md_stall}, 32'd0);
        @(negedge cpu_clk);
        md_bus.md_req = 1'b0;
        #1;
        check_eq({tag, " done one pulse"}, {31'd0, md_bus.md_done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int cyc2;
        int stalls;
        int seen;
        md_bus.md_req = 1'b0;
        md_bus.md_op  = 3'd0;
        md_bus.md_a   = '0;
        md_bus.md_b   = '0;

        #2;
        check_eq("reset result", md_bus.md_result, 32'd0);
        check_eq("reset busy", {31'd0, md_bus.md_busy}, 32'd0);
        check_eq("reset done", {31'd0, md_bus.md_done}, 32'd0);
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;

        run_op("mul 7*-3",    MdMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu",       MdMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh",        MdMulh,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu",      MdMulhsu, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF);
        run_op("div -7/2",    MdDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem -7/2",    MdRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu 100/7",  MdDivu,   32'd100,        32'd7,         32'd14);
        run_op("remu 100/7",  MdRemu,   32'd100,        32'd7,         32'd2);
        run_op("divu 5/0",    MdDivu,   32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("rem 5/0",     MdRem,    32'd5,          32'd0,         32'd5);
        run_op("div ovf",     MdDiv,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf",     MdRem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Abort at CALC iteration 10; last completed result (rem ovf) is 0, so use a
        // non-zero result first to make "unchanged" observable.
        run_op("divu 100/7 b", MdDivu,  32'd100,        32'd7,         32'd14);
        @(negedge cpu_clk);
        md_bus.md_req = 1'b1;
        md_bus.md_op  = MdMulhu;
        md_bus.md_a   = 32'hFFFF_FFFF;
        md_bus.md_b   = 32'hFFFF_FFFF;
        repeat (12) @(negedge cpu_clk);
        md_bus.md_req = 1'b0;
        #1;
        check_eq("abort busy before", {31'd0, md_bus.md_busy}, 32'd1);
        @(negedge cpu_clk);
        #1;
        check_eq("abort busy after", {31'd0, md_bus.md_busy}, 32'd0);
        check_eq("abort result kept", md_bus.md_result, 32'd14);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge cpu_clk);
            #1;
            if (md_bus.md_done) seen++;
        end
        check_eq("abort no done", 32'(seen), 32'd0);
        check_eq("abort result still", md_bus.md_result, 32'd14);
        run_op("mul 3*4", MdMul, 32'd3, 32'd4, 32'd12);

        // Reset in the middle of CALC.
        @(negedge cpu_clk);
        md_bus.md_req = 1'b1;
        md_bus.md_op  = MdDivu;
        md_bus.md_a   = 32'd100;
        md_bus.md_b   = 32'd7;
        repeat (15) @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #1;
        check_eq("rst result", md_bus.md_result, 32'd0);
        check_eq("rst busy", {31'd0, md_bus.md_busy}, 32'd0);
        check_eq("rst done", {31'd0, md_bus.md_done}, 32'd0);
        @(negedge cpu_clk);
        md_bus.md_req = 1'b0;
        cpu_rst       = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge cpu_clk);
            #1;
            if (md_bus.md_done || md_bus.md_busy) seen++;
        end
        check_eq("rst no done", 32'(seen), 32'd0);

        // Back-to-back with md_req held across DONE.
        @(negedge cpu_clk);
        md_bus.md_req = 1'b1;
        md_bus.md_op  = MdMul;
        md_bus.md_a   = 32'd6;
        md_bus.md_b   = 32'd7;
        wait_done(cyc, stalls);
        check_eq("b2b mul result", md_bus.md_result, 32'd42);
        check_eq("b2b mul latency", 32'(cyc), 32'd35);
        @(negedge cpu_clk);
        md_bus.md_op = MdDivu;
        md_bus.md_a  = 32'd42;
        md_bus.md_b  = 32'd5;
        wait_done(cyc2, stalls);
        check_eq("b2b divu result", md_bus.md_result, 32'd8);
        check_eq("b2b done gap", 32'(cyc2 + 1), 32'd36);
        @(negedge cpu_clk);
        md_bus.md_req = 1'b0;
        #1;
        check_eq("b2b done one pulse", {31'd0, md_bus.md_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
